stream_minmax_tracker: RTL and testbench

Downstream consumer of the 8-bit cascaded magnitude comparator. It accepts a framed stream of unsigned 8-bit samples over a valid/ready handshake and tracks the running maximum and minimum of each frame. For every frame it also tracks the sample count and how often the maximum value occurs. At the frame end it presents one result beat on a second valid/ready handshake, then returns to accepting samples.

---
 rtl/stream_minmax_tracker_pkg.sv | 13 +
 rtl/stream_minmax_tracker_if.sv | 29 ++
 rtl/mag_cmp8.sv | 37 +++
 rtl/minmax_update.sv | 71 +++++++
 rtl/stream_minmax_tracker.sv | 102 ++++++++++
 tb/tb_stream_minmax_tracker.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/stream_minmax_tracker_pkg.sv
// Shared types and constants for the frame min/max tracker.
package minmax_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int            SAMPLE_W = 8;
    localparam logic [7:0]    MIN_INIT = 8'hFF;

endpackage

// File: rtl/stream_minmax_tracker_if.sv
// Sample stream in, one result beat per frame out.
interface stream_minmax_tracker_if #(
    parameter int CNT_W = 8
);
    import minmax_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_max;
    logic [SAMPLE_W-1:0] out_min;
    logic [CNT_W-1:0]    out_count;
    logic [CNT_W-1:0]    out_max_ties;

    // Producer of samples and consumer of results.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_min, out_count, out_max_ties
    );

    // The tracker itself.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_min, out_count, out_max_ties
    );
endinterface

// File: rtl/mag_cmp8.sv
// 8-bit cascaded magnitude comparator. The cascade inputs decide the
// result only when a == b; each bit stage overrides lower stages when its
// bits differ, so the MSB stage has the final word.
module mag_cmp8
    import minmax_pkg::*;
(
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    input  logic                g_in,
    input  logic                q_in,
    input  logic                l_in,
    output logic                g_out,
    output logic                q_out,
    output logic                l_out
);
    logic [SAMPLE_W:0] g_chain;
    logic [SAMPLE_W:0] q_chain;
    logic [SAMPLE_W:0] l_chain;

    assign g_chain[0] = g_in;
    assign q_chain[0] = q_in;
    assign l_chain[0] = l_in;

    generate
        for (genvar gi = 0; gi < SAMPLE_W; gi++) begin : g_stage
            logic bit_eq;
            assign bit_eq          = ~(a[gi] ^ b[gi]);
            assign g_chain[gi + 1] = (a[gi] & ~b[gi]) | (bit_eq & g_chain[gi]);
            assign l_chain[gi + 1] = (~a[gi] & b[gi]) | (bit_eq & l_chain[gi]);
            assign q_chain[gi + 1] = bit_eq & q_chain[gi];
        end
    endgenerate

    assign g_out = g_chain[SAMPLE_W];
    assign q_out = q_chain[SAMPLE_W];
    assign l_out = l_chain[SAMPLE_W];
endmodule

// File: rtl/minmax_update.sv
// Next-state values for one accepted non-first sample of a frame:
// running max/min, saturating sample count and max-tie count.
module minmax_update
    import minmax_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic [SAMPLE_W-1:0] max,
    input  logic [SAMPLE_W-1:0] min,
    input  logic [CNT_W-1:0]    ties,
    input  logic [CNT_W-1:0]    count,
    output logic [SAMPLE_W-1:0] max_next,
    output logic [SAMPLE_W-1:0] min_next,
    output logic [CNT_W-1:0]    ties_next,
    output logic [CNT_W-1:0]    count_next
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // {greater, equal, less} of in_data against the running max / min
    logic [2:0] max_rel;
    logic [2:0] min_rel;

    mag_cmp8 u_cmp_max (
        .a     (in_data),
        .b     (max),
        .g_in  (1'b0),
        .q_in  (1'b1),
        .l_in  (1'b0),
        .g_out (max_rel[2]),
        .q_out (max_rel[1]),
        .l_out (max_rel[0])
    );

    mag_cmp8 u_cmp_min (
        .a     (in_data),
        .b     (min),
        .g_in  (1'b0),
        .q_in  (1'b1),
        .l_in  (1'b0),
        .g_out (min_rel[2]),
        .q_out (min_rel[1]),
        .l_out (min_rel[0])
    );

    // Max and tie count: a new max restarts the ties at one, a repeat bumps them.
    always_comb begin
        max_next  = max;
        ties_next = ties;
        case (max_rel)
            3'b100: begin
                max_next  = in_data;
                ties_next = CNT_ONE;
            end
            3'b010: ties_next = (ties == CNT_MAX) ? ties : ties + CNT_ONE;
            default: ;
        endcase
    end

    // Min only moves on a strictly smaller sample.
    always_comb begin
        min_next = min;
        case (min_rel)
            3'b001:  min_next = in_data;
            default: ;
        endcase
    end

    assign count_next = (count == CNT_MAX) ? count : count + CNT_ONE;
endmodule

// File: rtl/stream_minmax_tracker.sv
// Tracks max/min/count/max-ties of each framed sample stream and offers one
// result beat per frame. Results are held in HOLD until accepted.
module stream_minmax_tracker
    import minmax_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    stream_minmax_tracker_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state_reg;
    logic [SAMPLE_W-1:0] max_reg;
    logic [SAMPLE_W-1:0] min_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [CNT_W-1:0]    ties_reg;
    logic                out_valid_reg;

    logic [SAMPLE_W-1:0] max_next;
    logic [SAMPLE_W-1:0] min_next;
    logic [CNT_W-1:0]    count_next;
    logic [CNT_W-1:0]    ties_next;

    logic                in_ready;
    logic                accept;

    // Ready whenever not holding a result; forced low while reset is applied.
    assign in_ready = ~rst && (state_reg != HOLD);
    assign accept   = bus.in_valid && in_ready;

    minmax_update #(.CNT_W(CNT_W)) u_update (
        .in_data    (bus.in_data),
        .max        (max_reg),
        .min        (min_reg),
        .ties       (ties_reg),
        .count      (count_reg),
        .max_next   (max_next),
        .min_next   (min_next),
        .ties_next  (ties_next),
        .count_next (count_next)
    );

    // Frame FSM with registered result and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            max_reg       <= '0;
            min_reg       <= MIN_INIT;
            count_reg     <= '0;
            ties_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        max_reg   <= bus.in_data;
                        min_reg   <= bus.in_data;
                        count_reg <= CNT_ONE;
                        ties_reg  <= CNT_ONE;
                        if (bus.in_last) begin
                            state_reg     <= HOLD;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        max_reg   <= max_next;
                        min_reg   <= min_next;
                        count_reg <= count_next;
                        ties_reg  <= ties_next;
                        if (bus.in_last) begin
                            state_reg     <= HOLD;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_max      = max_reg;
    assign bus.out_min      = min_reg;
    assign bus.out_count    = count_reg;
    assign bus.out_max_ties = ties_reg;
endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Directed and randomized frames checked against a prefix-based frame model.
module tb_stream_minmax_tracker;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    stream_minmax_tracker_if #(.CNT_W(CNT_W)) bus_if ();

    stream_minmax_tracker #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] frame_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: statistics of the first k samples of frame_q.
    function automatic int ref_max(input int k);
        int m = 0;
        for (int i = 0; i < k; i++) if (int'(frame_q[i]) > m) m = int'(frame_q[i]);
        return m;
    endfunction

    function automatic int ref_min(input int k);
        int m = 255;
        for (int i = 0; i < k; i++) if (int'(frame_q[i]) < m) m = int'(frame_q[i]);
        return m;
    endfunction

    function automatic int ref_count(input int k);
        return (k > CMAX) ? CMAX : k;
    endfunction

    function automatic int ref_ties(input int k);
        int t = 0;
        int m = ref_max(k);
        for (int i = 0; i < k; i++) if (int'(frame_q[i]) == m) t++;
        return (t > CMAX) ? CMAX : t;
    endfunction

    task automatic check_stats(input string tag, input int k);
        check({tag, "_max"},   32'(bus_if.out_max),      32'(ref_max(k)));
        check({tag, "_min"},   32'(bus_if.out_min),      32'(ref_min(k)));
        check({tag, "_count"}, 32'(bus_if.out_count),    32'(ref_count(k)));
        check({tag, "_ties"},  32'(bus_if.out_max_ties), 32'(ref_ties(k)));
    endtask

    // Entered and left at a falling edge; the sample is accepted at the
    // rising edge in between, after an optional number of idle gap cycles.
    task automatic send_sample(input logic [7:0] d, input logic last, input int max_gaps);
        int gaps;
        gaps = $urandom_range(0, max_gaps);
        for (int g = 0; g < gaps; g++) begin
            bus_if.in_valid = 1'b0;
            bus_if.in_data  = 8'($urandom);
            bus_if.in_last  = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        bus_if.in_last  = last;
        check("in_ready_accept", 32'(bus_if.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'($urandom);
        bus_if.in_last  = 1'($urandom);
    endtask

    // Sends frame_q, checks running and final results, stalls the result
    // for hold cycles (with junk samples offered), then accepts it.
    task automatic run_frame(input string name, input int hold, input int max_gaps);
        int n;
        n = frame_q.size();
        for (int k = 0; k < n; k++) begin
            send_sample(frame_q[k], (k == n - 1), max_gaps);
            check({name, "_out_valid"}, 32'(bus_if.out_valid), 32'(k == n - 1));
            check_stats(name, k + 1);
        end
        check({name, "_ready_in_hold"}, 32'(bus_if.in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            bus_if.in_valid = 1'($urandom);
            bus_if.in_data  = 8'($urandom);
            bus_if.in_last  = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({name, "_hold_valid"}, 32'(bus_if.out_valid), 32'd1);
            check({name, "_hold_ready"}, 32'(bus_if.in_ready), 32'd0);
            check_stats({name, "_hold"}, n);
        end
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = 8'($urandom);
        bus_if.in_last   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b0;
        check({name, "_valid_drop"}, 32'(bus_if.out_valid), 32'd0);
        check({name, "_idle_ready"}, 32'(bus_if.in_ready), 32'd1);
        check_stats({name, "_after"}, n);
        $display("frame %s: len=%0d max=%0d min=%0d count=%0d ties=%0d", name, n,
                 bus_if.out_max, bus_if.out_min, bus_if.out_count, bus_if.out_max_ties);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(bus_if.out_valid),    32'd0);
        check({tag, "_max"},   32'(bus_if.out_max),      32'd0);
        check({tag, "_min"},   32'(bus_if.out_min),      32'hFF);
        check({tag, "_count"}, 32'(bus_if.out_count),    32'd0);
        check({tag, "_ties"},  32'(bus_if.out_max_ties), 32'd0);
        check({tag, "_ready"}, 32'(bus_if.in_ready),     32'd0);
    endtask

    initial begin
        int len;
        int mode;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = 8'd0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus_if.in_ready), 32'd1);
        @(negedge clk);

        frame_q = {8'd5, 8'd200, 8'd17, 8'd200, 8'd3};
        run_frame("basic", 0, 0);

        frame_q = {8'd42};
        run_frame("single", 0, 0);

        frame_q = {8'd9, 8'd9, 8'd9};
        run_frame("stall", 4, 0);

        frame_q.delete();
        for (int i = 0; i < 20; i++) frame_q.push_back(8'd255);
        run_frame("saturate", 1, 0);

        frame_q = {8'd0, 8'd128, 8'd255};
        run_frame("gaps", 0, 3);

        // Reset in the middle of a frame discards it immediately.
        frame_q = {8'd10, 8'd50};
        send_sample(8'd10, 1'b0, 0);
        send_sample(8'd50, 1'b0, 0);
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_midreset", 32'(bus_if.in_ready), 32'd1);
        frame_q = {8'd7};
        run_frame("post_reset", 0, 0);

        // Random frames; narrow value ranges exercise ties and saturation.
        for (int f = 0; f < 40; f++) begin
            frame_q.delete();
            len  = $urandom_range(1, 20);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) begin
                case (mode)
                    0:       frame_q.push_back(8'($urandom));
                    1:       frame_q.push_back(8'($urandom_range(0, 3)));
                    default: frame_q.push_back(8'($urandom_range(250, 255)));
                endcase
            end
            run_frame($sformatf("rand%0d", f), $urandom_range(0, 3), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
